// File: rtl/traffic_light_pkg.sv
// Shared lamp/error encodings for the traffic light controller and its monitor.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        LAMP_RED     = 2'd0,
        LAMP_GREEN   = 2'd1,
        LAMP_YELLOW  = 2'd2,
        LAMP_INVALID = 2'd3
    } lamp_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_BAD_LAMP  = 3'd1,
        ERR_BAD_SEQ   = 3'd2,
        ERR_TOO_LONG  = 3'd3,
        ERR_TOO_SHORT = 3'd4
    } err_e;

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } mon_state_e;

    function automatic lamp_e next_lamp(input lamp_e l);
        case (l)
            LAMP_RED:    return LAMP_GREEN;
            LAMP_GREEN:  return LAMP_YELLOW;
            LAMP_YELLOW: return LAMP_RED;
            default:     return LAMP_INVALID;
        endcase
    endfunction

    function automatic lamp_e decode_lamps(input logic r, input logic g, input logic y);
        case ({r, g, y})
            3'b100:  return LAMP_RED;
            3'b010:  return LAMP_GREEN;
            3'b001:  return LAMP_YELLOW;
            default: return LAMP_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_timer.sv
// Saturating phase-duration counter with over/under compare against exp +/- TOL.
module tl_phase_timer #(
    parameter int CNT_W = 16,
    parameter int TOL   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    input  logic [CNT_W-1:0] exp_len,
    output logic [CNT_W-1:0] dur,
    output logic             too_long,
    output logic             too_short
);

    localparam logic [CNT_W:0] TOL_X = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0] ONE_X = (CNT_W+1)'(1);

    logic [CNT_W-1:0] dur_q, dur_d;
    logic             sat;
    logic [CNT_W:0]   long_lim, short_lim, exp_x;

    always_comb begin
        sat   = &dur_q;
        exp_x = {1'b0, exp_len};
        dur_d = dur_q;
        if (reload) begin
            dur_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!sat) begin
            dur_d = dur_q + 1'b1;
        end
        long_lim  = exp_x + TOL_X;
        // Lower bound never drops below one sample.
        short_lim = (exp_x > TOL_X) ? (exp_x - TOL_X) : ONE_X;
        // Fires only on the step that takes dur to exp+TOL+1.
        too_long  = !reload && !sat && ({1'b0, dur_q} == long_lim);
        too_short = {1'b0, dur_q} < short_lim;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dur_q <= '0;
        end else begin
            dur_q <= dur_d;
        end
    end

    assign dur = dur_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-sequence monitor: phase order, phase timing and sticky first-error capture.
// state      | meaning
// ST_ACQUIRE | waiting for a legal transition between valid codes; no timing checks
// ST_TRACK   | synchronised; phase lengths checked and cycles counted
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES    = 20,
    parameter int GREEN_CYCLES  = 20,
    parameter int YELLOW_CYCLES = 5,
    parameter int TOL           = 0,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             red,
    input  logic             green,
    input  logic             yellow,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] phase_len
);

    lamp_e            phase_q, phase_d, cur;
    mon_state_e       state_q, state_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    err_e             err_code_q, err_code_d, new_err, base_err;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] phase_len_q, phase_len_d;
    logic [CNT_W-1:0] exp_len, dur;
    logic             changed, legal, illegal_valid, too_long, too_short;

    always_comb begin
        case (phase_q)
            LAMP_RED:    exp_len = CNT_W'(RED_CYCLES);
            LAMP_GREEN:  exp_len = CNT_W'(GREEN_CYCLES);
            LAMP_YELLOW: exp_len = CNT_W'(YELLOW_CYCLES);
            default:     exp_len = '0;
        endcase
    end

    tl_phase_timer #(
        .CNT_W (CNT_W),
        .TOL   (TOL)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .reload    (changed),
        .exp_len   (exp_len),
        .dur       (dur),
        .too_long  (too_long),
        .too_short (too_short)
    );

    always_comb begin
        cur           = decode_lamps(red, green, yellow);
        phase_d       = cur;
        state_d       = state_q;
        locked_d      = locked_q;
        cycle_count_d = cycle_count_q;
        phase_len_d   = phase_len_q;
        new_err       = ERR_NONE;

        changed       = (cur != phase_q);
        legal         = changed && (cur != LAMP_INVALID) && (phase_q != LAMP_INVALID)
                        && (cur == next_lamp(phase_q));
        illegal_valid = changed && (cur != LAMP_INVALID) && (phase_q != LAMP_INVALID) && !legal;

        if (cur == LAMP_INVALID) begin
            new_err  = ERR_BAD_LAMP;
            state_d  = ST_ACQUIRE;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACQUIRE: begin
                    if (legal) begin
                        state_d  = ST_TRACK;
                        locked_d = 1'b1;
                    end else if (illegal_valid) begin
                        new_err = ERR_BAD_SEQ;
                    end
                end
                ST_TRACK: begin
                    if (illegal_valid) begin
                        new_err  = ERR_BAD_SEQ;
                        state_d  = ST_ACQUIRE;
                        locked_d = 1'b0;
                    end else if (legal) begin
                        phase_len_d = dur;
                        if (too_short) new_err = ERR_TOO_SHORT;
                        if (phase_q == LAMP_YELLOW) cycle_count_d = cycle_count_q + 1'b1;
                    end else if (too_long) begin
                        new_err = ERR_TOO_LONG;
                    end
                end
                default: begin
                    state_d  = ST_ACQUIRE;
                    locked_d = 1'b0;
                end
            endcase
        end

        // A clear in the same cycle as a new error still captures the new code.
        base_err   = clr_err ? ERR_NONE : err_code_q;
        err_code_d = (base_err == ERR_NONE) ? new_err : base_err;
        err_d      = (err_code_d != ERR_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= LAMP_INVALID;
            state_q       <= ST_ACQUIRE;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
            cycle_count_q <= '0;
            phase_len_q   <= '0;
        end else begin
            phase_q       <= phase_d;
            state_q       <= state_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            cycle_count_q <= cycle_count_d;
            phase_len_q   <= phase_len_d;
        end
    end

    assign phase       = phase_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign cycle_count = cycle_count_q;
    assign phase_len   = phase_len_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor (RED=4 GREEN=3 YELLOW=2; TOL=0 and TOL=1 copies).
module tb_traffic_light_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        red = 1'b0, green = 1'b0, yellow = 1'b0;
    logic        clr_err = 1'b0;

    logic [1:0]  phase, phase_t;
    logic        locked, locked_t, err, err_t;
    logic [2:0]  err_code, err_code_t;
    logic [15:0] cycle_count, cycle_count_t, phase_len, phase_len_t;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    localparam int RR = 0, GG = 1, YY = 2;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .RED_CYCLES(4), .GREEN_CYCLES(3), .YELLOW_CYCLES(2), .TOL(0), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .red(red), .green(green), .yellow(yellow), .clr_err(clr_err),
        .phase(phase), .locked(locked), .err(err), .err_code(err_code),
        .cycle_count(cycle_count), .phase_len(phase_len)
    );

    traffic_light_monitor #(
        .RED_CYCLES(4), .GREEN_CYCLES(3), .YELLOW_CYCLES(2), .TOL(1), .CNT_W(16)
    ) dut_t (
        .clk(clk), .rst(rst), .red(red), .green(green), .yellow(yellow), .clr_err(clr_err),
        .phase(phase_t), .locked(locked_t), .err(err_t), .err_code(err_code_t),
        .cycle_count(cycle_count_t), .phase_len(phase_len_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vec_cnt++;
        if (got !== expv) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    task automatic step(input logic r, input logic g, input logic y);
        @(negedge clk);
        red = r; green = g; yellow = y;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int code, input int n);
        repeat (n) step(code == RR, code == GG, code == YY);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Normal sequence
        do_reset();
        check("rst_phase",  32'(phase), 3);
        check("rst_locked", 32'(locked), 0);
        check("rst_err",    32'(err), 0);
        check("rst_code",   32'(err_code), 0);
        check("rst_count",  32'(cycle_count), 0);
        check("rst_len",    32'(phase_len), 0);
        run(RR, 4);
        check("acq_phase",  32'(phase), 0);
        check("acq_locked", 32'(locked), 0);
        run(GG, 1);
        check("lock_phase", 32'(phase), 1);
        check("lock_on_rg", 32'(locked), 1);
        run(GG, 2);
        run(YY, 1);
        check("len_green",  32'(phase_len), 3);
        run(YY, 1);
        run(RR, 1);
        check("len_yel1",   32'(phase_len), 2);
        check("count1",     32'(cycle_count), 1);
        run(RR, 3); run(GG, 3); run(YY, 2); run(RR, 1);
        check("len_yel2",   32'(phase_len), 2);
        check("count2",     32'(cycle_count), 2);
        check("norm_err",   32'(err), 0);
        run(RR, 3);
        check("norm_code",  32'(err_code), 0);

        // Too long green
        do_reset();
        run(RR, 4); run(GG, 3);
        check("tl_pre",     32'(err_code), 0);
        run(GG, 1);
        check("tl_code",    32'(err_code), 3);
        check("tl_err",     32'(err), 1);
        run(GG, 1); run(YY, 2); run(RR, 1);
        check("tl_count",   32'(cycle_count), 1);
        check("tl_hold",    32'(err_code), 3);

        // Too short yellow
        do_reset();
        run(RR, 4); run(GG, 3); run(YY, 1); run(RR, 1);
        check("ts_code",    32'(err_code), 4);
        check("ts_len",     32'(phase_len), 1);
        check("ts_locked",  32'(locked), 1);

        // Bad sequence RED -> YELLOW, then relock on Y->R
        do_reset();
        run(RR, 4); run(GG, 3); run(YY, 2); run(RR, 2);
        run(YY, 1);
        check("bs_code",    32'(err_code), 2);
        check("bs_locked",  32'(locked), 0);
        run(YY, 1); run(RR, 1);
        check("bs_relock",  32'(locked), 1);
        check("bs_count",   32'(cycle_count), 1);
        run(RR, 3); run(GG, 3);
        check("bs_hold",    32'(err_code), 2);

        // Bad lamp, later too-long keeps first code, then clear
        do_reset();
        run(RR, 4); run(GG, 1);
        step(1'b1, 1'b1, 1'b0);
        check("bl_phase",   32'(phase), 3);
        check("bl_code",    32'(err_code), 1);
        check("bl_locked",  32'(locked), 0);
        run(RR, 4); run(GG, 1);
        check("bl_relock",  32'(locked), 1);
        run(GG, 3);
        check("bl_first",   32'(err_code), 1);
        clr_err = 1'b1;
        run(GG, 1);
        clr_err = 1'b0;
        check("clr_err",    32'(err), 0);
        check("clr_code",   32'(err_code), 0);

        // Reset mid-green
        do_reset();
        run(RR, 4); run(GG, 2);
        rst = 1'b1;
        run(GG, 1);
        rst = 1'b0;
        check("mr_phase",   32'(phase), 3);
        check("mr_locked",  32'(locked), 0);
        check("mr_count",   32'(cycle_count), 0);
        check("mr_len",     32'(phase_len), 0);
        check("mr_code",    32'(err_code), 0);

        // Clear coincident with a new BAD_SEQ
        do_reset();
        run(RR, 4); run(GG, 1);
        step(1'b1, 1'b1, 1'b0);
        run(RR, 4); run(GG, 1);
        clr_err = 1'b1;
        run(RR, 1);
        clr_err = 1'b0;
        check("clrseq_err",  32'(err), 1);
        check("clrseq_code", 32'(err_code), 2);

        // Tolerance: G x4 legal with TOL=1, too long with TOL=0
        do_reset();
        run(RR, 4); run(GG, 4); run(YY, 2); run(RR, 1);
        check("tol1_err",   32'(err_t), 0);
        check("tol1_len",   32'(phase_len_t), 2);
        check("tol1_count", 32'(cycle_count_t), 1);
        check("tol0_code",  32'(err_code), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the red/green/yellow lamp outputs of the traffic light controller: the observing end of that lamp interface.
- Decodes the lamp pattern and tracks phase order RED→GREEN→YELLOW→RED.
- Measures each phase's duration against expected lengths and counts completed cycles.
- Flags protocol violations with a sticky error code. Used in system benches and as an on-chip health monitor.

Parameters:
- RED_CYCLES, 20, expected red phase length in clk cycles
- GREEN_CYCLES, 20, expected green phase length in clk cycles
- YELLOW_CYCLES, 5, expected yellow phase length in clk cycles
- TOL, 0, allowed ± deviation in cycles per phase
- CNT_W, 16, width of duration and cycle counters

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- red  in  1  red lamp
- green  in  1  green lamp
- yellow  in  1  yellow lamp
- clr_err  in  1  clears err/err_code
- phase  out  2  registered lamp code: 0=RED 1=GREEN 2=YELLOW 3=INVALID
- locked  out  1  monitor synchronised to the phase sequence
- err  out  1  sticky error flag
- err_code  out  3  first error since clear: 0=NONE 1=BAD_LAMP 2=BAD_SEQ 3=TOO_LONG 4=TOO_SHORT
- cycle_count  out  CNT_W  completed YELLOW→RED transitions while locked, wraps
- phase_len  out  CNT_W  measured length of last completed phase

Behaviour:
- Reset (rst=1 at posedge): phase=3, locked=0, err=0, err_code=0, cycle_count=0, phase_len=0, dur=0, state ACQUIRE. Reset mid-phase discards all measurement.
- Lamp inputs are registered once. phase reflects inputs with 1-cycle latency. Not exactly one lamp high → code 3.
- dur = consecutive samples of the current code, including the first. Saturates at all-ones. Reloads to 1 on a code change.
- Legal successor: RED→GREEN, GREEN→YELLOW, YELLOW→RED.
- State ACQUIRE:
  - Entry phase length is unknown, so no timing checks.
  - Legal code change → TRACK, locked=1, dur=1.
  - Illegal change between valid codes → BAD_SEQ, stay in ACQUIRE.
- State TRACK:
  - Code unchanged, dur reaches EXP+TOL+1 → TOO_LONG. Raised once per phase, tracking continues.
  - Legal change with dur < EXP−TOL (floored at 1) → TOO_SHORT. phase_len=dur, tracking continues.
  - Legal change within limits → phase_len=dur.
  - Any YELLOW→RED → cycle_count+1 (mod 2^CNT_W).
  - Illegal change → BAD_SEQ, locked=0, go to ACQUIRE.
- Invalid code (3) in any state → BAD_LAMP, locked=0, go to ACQUIRE. Recovery requires one legal transition between valid codes.
- Error recording:
  - err_code is written only when currently 0, so the first error is held.
  - Simultaneous errors use priority BAD_LAMP > BAD_SEQ > TOO_SHORT > TOO_LONG.
  - clr_err zeroes err and err_code. A new error in the same cycle as clr_err wins: err=1 with the new code.
- err = (err_code != 0), registered.

Decomposition:
- traffic_light_pkg holds:
  - lamp_e enum (RED/GREEN/YELLOW/INVALID)
  - err_e enum
  - function next_lamp(lamp_e)
  - function decode_lamps(r,g,y) returning lamp_e
- The controller and this monitor share the package.
- One natural sub-module: tl_phase_timer (saturating CNT_W counter with reload and over/under compare against EXP±TOL). Instantiated once, with EXP selected by the current code.

Test Plan (RED=4, GREEN=3, YELLOW=2, TOL=0 unless noted):
- Reset, drive R×4 G×3 Y×2 R×4 G×3 Y×2 R×4 → locked=1 one cycle after first R→G is registered, err=0, cycle_count=2, phase_len=2 after each Y→R.
- Legal lock then G×5 → err_code=3 (TOO_LONG) when dur=4, err=1. Subsequent Y→R still increments cycle_count.
- Legal lock then Y×1 → err_code=4 (TOO_SHORT), phase_len=1, locked stays 1.
- Locked on RED then YELLOW → err_code=2, locked=0. Then Y×2 R×4 G×3 → relocks on Y→R, cycle_count unchanged by the illegal step.
- red=green=1 for 1 cycle → phase=3 next cycle, err_code=1, locked=0. Then a TOO_LONG event leaves err_code=1. clr_err pulse → err=0, err_code=0.
- rst asserted mid-GREEN (dur=2) → all outputs return to reset values the following cycle. clr_err coincident with BAD_SEQ → err=1, err_code=2. With TOL=1, G×4 produces no error.
